glitch_sequencer: RTL and testbench

- Parametrised successor to the glitch controller's pulse path.
- Sequence: optional target-reset phase, wait for a synchronised external trigger edge (or a software fire), programmable delay, then a train of N pulses with programmable width and spacing.
- Sits between the UART register handler, which supplies config and arm/abort strobes, and the glitch output pins; replaces the free-running pulser.

---
 rtl/glitch_sequencer_pkg.sv | 27 ++
 rtl/glitch_sequencer_if.sv | 31 +++
 rtl/glitch_sequencer_trigger_sync.sv | 33 +++
 rtl/glitch_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/glitch_sequencer_pkg.sv
// Shared state encoding, trigger-mode encodings and small helpers for the glitch sequencer.
package glitch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_TGT   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_DELAY     = 3'd3,
    ST_PULSE     = 3'd4,
    ST_SPACE     = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  localparam logic [1:0] MODE_RISE = 2'd0;
  localparam logic [1:0] MODE_FALL = 2'd1;
  localparam logic [1:0] MODE_SW   = 2'd2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Software fire skips the trigger wait; every other mode (reserved included) waits for an edge.
  function automatic state_e post_reset_state(input logic [1:0] mode);
    return (mode == MODE_SW) ? ST_DELAY : ST_WAIT_TRIG;
  endfunction

endpackage

// File: rtl/glitch_sequencer_if.sv
// Control/status bundle between the UART register handler (master) and the sequencer (slave).
interface glitch_sequencer_if #(
  parameter int DELAY_W   = 24,
  parameter int WIDTH_W   = 16,
  parameter int COUNT_W   = 8,
  parameter int SPACING_W = 16,
  parameter int RESET_W   = 16
) ();
  logic                 arm_i;
  logic                 abort_i;
  logic [1:0]           mode_i;
  logic [DELAY_W-1:0]   delay_i;
  logic [WIDTH_W-1:0]   width_i;
  logic [COUNT_W-1:0]   num_pulses_i;
  logic [SPACING_W-1:0] spacing_i;
  logic [RESET_W-1:0]   reset_len_i;
  logic                 busy_o;
  logic                 armed_o;
  logic                 done_o;
  logic [COUNT_W-1:0]   pulse_count_o;

  modport master (
    output arm_i, abort_i, mode_i, delay_i, width_i, num_pulses_i, spacing_i, reset_len_i,
    input  busy_o, armed_o, done_o, pulse_count_o
  );

  modport slave (
    input  arm_i, abort_i, mode_i, delay_i, width_i, num_pulses_i, spacing_i, reset_len_i,
    output busy_o, armed_o, done_o, pulse_count_o
  );
endinterface

// File: rtl/glitch_sequencer_trigger_sync.sv
// Trigger synchroniser chain plus a free-running previous-value flop; emits edge strobes.
module trigger_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw trigger in; prev tracks the synchronised level one cycle late.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and previous-value registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/glitch_sequencer.sv
// Glitch pulse sequencer: optional target reset, trigger wait, delay, then a train of pulses.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int DELAY_W     = 24,
  parameter int WIDTH_W     = 16,
  parameter int COUNT_W     = 8,
  parameter int SPACING_W   = 16,
  parameter int RESET_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger_i,
  output logic               pulse_o,
  output logic               target_reset_o,
  glitch_sequencer_if.slave  ctl
);
  localparam int CNT_W = max2(max2(DELAY_W, WIDTH_W), max2(SPACING_W, RESET_W));

  state_e               state_q, state_d, fsm_next_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [COUNT_W-1:0]   num_q, num_d;
  logic [SPACING_W-1:0] spacing_q, spacing_d;
  logic [COUNT_W-1:0]   count_q, count_d, count_next_s;
  logic                 pulse_q, pulse_d, tgt_rst_q, tgt_rst_d;
  logic                 busy_q, busy_d, armed_q, armed_d, done_q, done_d;
  logic                 rise_s, fall_s, trig_edge_s, abort_hit_s;

  trigger_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trigger_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (trigger_i),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  // Select the edge strobe for the latched trigger mode.
  always_comb begin
    case (mode_q)
      MODE_RISE: trig_edge_s = rise_s;
      MODE_FALL: trig_edge_s = fall_s;
      default:   trig_edge_s = rise_s;
    endcase
  end

  // Next-state, phase counter and config latch; counters compare before decrementing so
  // all-ones field values never wrap.
  always_comb begin
    fsm_next_s   = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    delay_d      = delay_q;
    width_d      = width_q;
    num_d        = num_q;
    spacing_d    = spacing_q;
    count_next_s = count_q;
    case (state_q)
      ST_IDLE: begin
        if (ctl.arm_i && !ctl.abort_i) begin
          mode_d       = ctl.mode_i;
          delay_d      = ctl.delay_i;
          width_d      = ctl.width_i;
          num_d        = ctl.num_pulses_i;
          spacing_d    = ctl.spacing_i;
          count_next_s = '0;
          if (ctl.reset_len_i != '0) begin
            fsm_next_s = ST_RST_TGT;
            cnt_d      = CNT_W'(ctl.reset_len_i);
          end else begin
            fsm_next_s = post_reset_state(ctl.mode_i);
            cnt_d      = CNT_W'(ctl.delay_i);
          end
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_RST_TGT: begin
        if (cnt_q == CNT_W'(1)) begin
          fsm_next_s = post_reset_state(mode_q);
          cnt_d      = CNT_W'(delay_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_TRIG: begin
        if (trig_edge_s) begin
          fsm_next_s = ST_DELAY;
        end else begin
          fsm_next_s = ST_WAIT_TRIG;
        end
      end
      ST_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if ((width_q == '0) || (num_q == '0)) begin
          fsm_next_s = ST_DONE;
        end else begin
          fsm_next_s   = ST_PULSE;
          cnt_d        = CNT_W'(width_q);
          count_next_s = count_q + COUNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q != CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (count_q == num_q) begin
          fsm_next_s = ST_DONE;
        end else if (spacing_q == '0) begin
          // Zero spacing chains pulses back to back into one merged high.
          cnt_d        = CNT_W'(width_q);
          count_next_s = count_q + COUNT_W'(1);
        end else begin
          fsm_next_s = ST_SPACE;
          cnt_d      = CNT_W'(spacing_q);
        end
      end
      ST_SPACE: begin
        if (cnt_q == CNT_W'(1)) begin
          fsm_next_s   = ST_PULSE;
          cnt_d        = CNT_W'(width_q);
          count_next_s = count_q + COUNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: fsm_next_s = ST_IDLE;
      default: fsm_next_s = ST_IDLE;
    endcase
  end

  // Abort overrides everything outside IDLE and freezes the partial pulse count.
  always_comb begin
    abort_hit_s = ctl.abort_i && (state_q != ST_IDLE);
    state_d     = abort_hit_s ? ST_IDLE : fsm_next_s;
    count_d     = abort_hit_s ? count_q : count_next_s;
  end

  // Output decode from the next state so every output is a flop aligned with the state.
  always_comb begin
    pulse_d   = (state_d == ST_PULSE);
    tgt_rst_d = (state_d == ST_RST_TGT);
    busy_d    = (state_d != ST_IDLE);
    armed_d   = (state_d == ST_WAIT_TRIG);
    done_d    = (state_d == ST_DONE);
  end

  // State, counter, config and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= 2'd0;
      delay_q   <= '0;
      width_q   <= '0;
      num_q     <= '0;
      spacing_q <= '0;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      tgt_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      num_q     <= num_d;
      spacing_q <= spacing_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      tgt_rst_q <= tgt_rst_d;
      busy_q    <= busy_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
    end
  end

  assign pulse_o           = pulse_q;
  assign target_reset_o    = tgt_rst_q;
  assign ctl.busy_o        = busy_q;
  assign ctl.armed_o       = armed_q;
  assign ctl.done_o        = done_q;
  assign ctl.pulse_count_o = count_q;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomised bench for glitch_sequencer: each sequence's waveform is predicted cycle by cycle
// from its configuration using closed-form timing arithmetic.
module tb_glitch_sequencer;
  import glitch_pkg::*;

  localparam int DW = 6;
  localparam int WW = 4;
  localparam int CW = 3;
  localparam int SW = 3;
  localparam int RW = 4;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trig = 1'b0;
  logic pulse, tgt;
  int   checks = 0;
  int   failures = 0;
  int   last_count = 0;

  glitch_sequencer_if #(.DELAY_W(DW), .WIDTH_W(WW), .COUNT_W(CW), .SPACING_W(SW), .RESET_W(RW)) ctl ();

  glitch_sequencer #(
    .DELAY_W(DW), .WIDTH_W(WW), .COUNT_W(CW), .SPACING_W(SW), .RESET_W(RW), .SYNC_STAGES(SS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trigger_i      (trig),
    .pulse_o        (pulse),
    .target_reset_o (tgt),
    .ctl            (ctl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit ep, input bit et, input bit eb, input bit ea,
                               input bit ed, input int ec);
    check("pulse", 32'(pulse), 32'(ep));
    check("target_reset", 32'(tgt), 32'(et));
    check("busy", 32'(ctl.busy_o), 32'(eb));
    check("armed", 32'(ctl.armed_o), 32'(ea));
    check("done", 32'(ctl.done_o), 32'(ed));
    check("pulse_count", 32'(ctl.pulse_count_o), ec);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic noise();
    ctl.mode_i       = 2'($urandom);
    ctl.delay_i      = DW'($urandom);
    ctl.width_i      = WW'($urandom);
    ctl.num_pulses_i = CW'($urandom);
    ctl.spacing_i    = SW'($urandom);
    ctl.reset_len_i  = RW'($urandom);
  endtask

  task automatic load_cfg(input logic [1:0] m, input int r, input int d, input int w,
                          input int n, input int s);
    ctl.mode_i       = m;
    ctl.delay_i      = DW'(d);
    ctl.width_i      = WW'(w);
    ctl.num_pulses_i = CW'(n);
    ctl.spacing_i    = SW'(s);
    ctl.reset_len_i  = RW'(r);
  endtask

  // One armed sequence; edge k counts posedges from the arm edge (k=0).
  task automatic run_seq(input logic [1:0] m, input int r, input int d, input int w, input int n,
                         input int s, input int abort_at, input bit pre_toggle);
    bit trig_mode, fall_mode, degen, ab, ep, et, ea;
    int e0, p, dn, keff, ec, off;
    trig_mode = (m != MODE_SW);
    fall_mode = (m == MODE_FALL);
    degen     = (w == 0) || (n == 0);
    trig = 1'b0;
    repeat (SS + 3) tick();
    if (pre_toggle) begin
      trig = 1'b1;
      repeat (2) tick();
      trig = 1'b0;
      repeat (SS + 3) tick();
    end
    check("idle_busy", 32'(ctl.busy_o), 32'd0);
    e0 = r + 4 + int'($urandom_range(0, 4));
    p  = trig_mode ? (e0 + SS + 1 + d) : (r + 1 + d);
    dn = degen ? p : (p + n * w + (n - 1) * s);
    load_cfg(m, r, d, w, n, s);
    ctl.arm_i = 1'b1;
    ctl.abort_i = 1'b0;
    for (int k = 0; k <= dn + 3; k++) begin
      tick();
      ab   = (abort_at > 0) && (k >= abort_at);
      keff = ab ? abort_at - 1 : k;
      et   = !ab && (k < r);
      ea   = !ab && trig_mode && (k >= r) && (k <= e0 + SS - 1);
      ep   = 1'b0;
      ec   = 0;
      if (!degen && !ab && k >= p) begin
        off = k - p;
        ep  = ((off / (w + s)) < n) && ((off % (w + s)) < w);
      end
      if (!degen && keff >= p) begin
        ec = ((keff - p) / (w + s)) + 1;
        if (ec > n) ec = n;
      end
      check_outputs(ep, et, !ab && (k <= dn), ea, !ab && (k == dn), ec);
      last_count = ec;
      // Drive inputs for edge k+1.
      noise();
      ctl.arm_i   = 1'b0;
      ctl.abort_i = (k + 1 == abort_at);
      if (trig_mode && fall_mode && (k + 1 == e0 - 3)) trig = 1'b1;
      if (trig_mode && fall_mode && (k + 1 == e0)) trig = 1'b0;
      if (trig_mode && !fall_mode && (k + 1 == e0)) trig = 1'b1;
      if ((k + 1 <= dn) && (abort_at <= 0 || k + 1 < abort_at) && ($urandom_range(0, 7) == 0))
        ctl.arm_i = 1'b1;
    end
    ctl.arm_i   = 1'b0;
    ctl.abort_i = 1'b0;
  endtask

  initial begin
    int m, r, d, w, n, s, ab;
    ctl.arm_i = 1'b0;
    ctl.abort_i = 1'b0;
    load_cfg(MODE_RISE, 0, 0, 0, 0, 0);
    @(negedge clk);
    repeat (3) tick();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    tick();

    run_seq(MODE_RISE, 0, 10, 3, 1, 0, -1, 1'b1);
    run_seq(MODE_SW, 5, 0, 2, 3, 4, -1, 1'b0);
    run_seq(MODE_FALL, 0, 3, 2, 2, 1, -1, 1'b0);
    run_seq(MODE_SW, 0, 0, 8, 4, 2, 13, 1'b0);
    check("abort_partial_count", 32'(ctl.pulse_count_o), 32'd2);
    run_seq(MODE_SW, 2, 4, 0, 3, 1, -1, 1'b0);
    run_seq(MODE_SW, 0, 2, 3, 0, 1, -1, 1'b0);
    run_seq(MODE_SW, 0, 1, 2, 3, 0, -1, 1'b0);
    run_seq(2'd3, 15, 63, 15, 7, 7, -1, 1'b1);

    // arm and abort together in IDLE: nothing starts, count untouched.
    load_cfg(MODE_SW, 0, 0, 2, 2, 1);
    ctl.arm_i = 1'b1;
    ctl.abort_i = 1'b1;
    tick();
    ctl.arm_i = 1'b0;
    ctl.abort_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_count);
      tick();
    end

    // Reset while the target reset is active.
    load_cfg(MODE_RISE, 10, 3, 2, 1, 1);
    ctl.arm_i = 1'b1;
    tick();
    ctl.arm_i = 1'b0;
    check("tgt_rst_active", 32'(tgt), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    tick();

    // Reset in the middle of a pulse clears the pulse and the count.
    load_cfg(MODE_SW, 0, 0, 8, 2, 1);
    ctl.arm_i = 1'b1;
    repeat (3) tick();
    ctl.arm_i = 1'b0;
    check("pulse_before_rst", 32'(pulse), 32'd1);
    rst = 1'b0;
    tick();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    tick();

    for (int it = 0; it < 40; it++) begin
      m = int'($urandom_range(0, 3));
      r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      d = int'($urandom_range(0, 12));
      w = int'($urandom_range(0, 5));
      n = int'($urandom_range(0, 4));
      s = int'($urandom_range(0, 3));
      ab = -1;
      if ($urandom_range(0, 3) == 0) begin
        if (w == 0 || n == 0) ab = int'($urandom_range(1, 3));
        else ab = int'($urandom_range(1, 3 + r + d + w * n));
      end
      run_seq(2'(m), r, d, w, n, s, ab, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
